lsu_hs: RTL and testbench

LSU_HS -- requirements
Module: lsu_hs

---
 rtl/lsu_hs.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_hs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_hs.sv
// Load/store handshake unit: accepts one RV load/store, decodes size and
// alignment, issues a single aligned memory beat with lane strobes, and
// returns extended load data with a one-cycle completion pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request (req_ready=1)
// MEM   | memory beat outstanding (mem_valid=1), wait counter running
// RESP  | one-cycle completion pulse (resp_valid=1), result registers fresh
module lsu_hs #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // Counter value seen in the last allowed MEM cycle; the timeout fires at
    // the edge that ends that cycle, giving exactly TIMEOUT MEM cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_BUS     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;

    // Request fields kept for the load return path.
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;

    logic              dec_illegal;
    logic              dec_misalign;
    logic [STRB_W-1:0] dec_strb;
    logic [OFF_W-1:0]  req_off;
    logic              accept;
    logic              go_mem;
    logic              go_bad;
    logic              mem_done;
    logic              mem_timeout;
    logic              timeout_hit;

    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_mask;
    logic              ld_sign;
    logic [XLEN-1:0]   ld_data;

    // Handshake and status outputs are pure functions of the state register;
    // req_ready is also gated by reset so it reads 0 while reset is held.
    assign req_ready  = (state == ST_IDLE) && !reset;
    assign mem_valid  = (state == ST_MEM);
    assign resp_valid = (state == ST_RESP);

    assign req_off     = req_addr[OFF_W-1:0];
    assign accept      = req_valid && req_ready;
    assign go_mem      = accept && !(dec_illegal || dec_misalign);
    assign go_bad      = accept &&  (dec_illegal || dec_misalign);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    assign mem_done    = (state == ST_MEM) && mem_ready;
    assign mem_timeout = (state == ST_MEM) && !mem_ready && timeout_hit;

    // Decode legality, alignment and the unshifted byte strobe of the request.
    always_comb begin
        dec_illegal  = 1'b0;
        dec_misalign = 1'b0;
        dec_strb     = '0;
        if (req_funct3 == 3'b111) begin
            dec_illegal = 1'b1;
        end
        if ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110))) begin
            dec_illegal = 1'b1;
        end
        if (req_we && req_funct3[2]) begin
            dec_illegal = 1'b1;
        end
        case (req_funct3[1:0])
            2'b00: begin
                dec_misalign = 1'b0;
                dec_strb     = STRB_W'(8'h01);
            end
            2'b01: begin
                dec_misalign = req_addr[0];
                dec_strb     = STRB_W'(8'h03);
            end
            2'b10: begin
                dec_misalign = |req_addr[1:0];
                dec_strb     = STRB_W'(8'h0F);
            end
            default: begin
                dec_misalign = |req_addr[2:0];
                dec_strb     = '1;
            end
        endcase
    end

    // Align returned data to bit 0, keep the access size and extend it.
    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        ld_mask  = '1;
        ld_sign  = ld_shift[XLEN-1];
        case (size_q)
            2'b00: begin
                ld_mask = XLEN'(8'hFF);
                ld_sign = ld_shift[7];
            end
            2'b01: begin
                ld_mask = XLEN'(16'hFFFF);
                ld_sign = ld_shift[15];
            end
            2'b10: begin
                ld_mask = XLEN'(32'hFFFF_FFFF);
                ld_sign = ld_shift[31];
            end
            default: begin
                ld_mask = '1;
                ld_sign = ld_shift[XLEN-1];
            end
        endcase
        ld_data = (ld_shift & ld_mask) | ((ld_sign && !uns_q) ? ~ld_mask : '0);
    end

    // State register: IDLE -> MEM or RESP on accept, MEM -> RESP on
    // completion or timeout, RESP always back to IDLE after one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_mem) begin
                        state <= ST_MEM;
                    end else if (go_bad) begin
                        state <= ST_RESP;
                    end
                end
                ST_MEM: begin
                    if (mem_done || mem_timeout) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the request beat, run the wait counter and register the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= '0;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            if (go_mem) begin
                mem_we    <= req_we;
                mem_addr  <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                mem_wstrb <= req_we ? (dec_strb << req_off) : '0;
                mem_wdata <= req_we ? (req_wdata << {req_off, 3'b000}) : '0;
                we_q      <= req_we;
                uns_q     <= req_funct3[2];
                size_q    <= req_funct3[1:0];
                off_q     <= req_off;
                wait_cnt  <= '0;
            end
            if (go_bad) begin
                resp_err   <= ERR_ILLEGAL;
                resp_rdata <= '0;
            end
            // A completion in the timeout cycle wins over the timeout.
            if (mem_done) begin
                resp_err   <= mem_err ? ERR_BUS : ERR_OK;
                resp_rdata <= we_q ? '0 : ld_data;
            end else if (mem_timeout) begin
                resp_err   <= ERR_TIMEOUT;
                resp_rdata <= '0;
            end else if (state == ST_MEM) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: a 32-bit instance with a short timeout and a
// 64-bit instance, selected per test, driven through one request task.
module tb_lsu_hs;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel64;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    logic        a_req_ready, a_resp_valid, a_mem_valid, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_resp_err;
    logic [3:0]  a_mem_wstrb;

    logic        b_req_ready, b_resp_valid, b_mem_valid, b_mem_we;
    logic [63:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_resp_err;
    logic [7:0]  b_mem_wstrb;

    logic        obs_req_ready, obs_resp_valid, obs_mem_valid, obs_mem_we;
    logic [63:0] obs_resp_rdata, obs_mem_addr, obs_mem_wdata;
    logic [1:0]  obs_resp_err;
    logic [7:0]  obs_mem_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    int          res_lat;
    logic        res_mv_seen, res_stable, res_mwe, res_mv_at_resp;
    logic [63:0] res_maddr, res_wdata, res_rdata, res_rdata_after;
    logic [7:0]  res_strb;
    logic [1:0]  res_err, res_err_after;
    logic        res_rv_after, res_ready_after;

    always #5 clock = ~clock;

    lsu_hs #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && !sel64), .req_ready(a_req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err)
    );

    lsu_hs #(.XLEN(64)) dut64 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel64), .req_ready(b_req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    assign obs_req_ready  = sel64 ? b_req_ready  : a_req_ready;
    assign obs_resp_valid = sel64 ? b_resp_valid : a_resp_valid;
    assign obs_mem_valid  = sel64 ? b_mem_valid  : a_mem_valid;
    assign obs_mem_we     = sel64 ? b_mem_we     : a_mem_we;
    assign obs_resp_rdata = sel64 ? b_resp_rdata : {32'h0, a_resp_rdata};
    assign obs_mem_addr   = sel64 ? b_mem_addr   : {32'h0, a_mem_addr};
    assign obs_mem_wdata  = sel64 ? b_mem_wdata  : {32'h0, a_mem_wdata};
    assign obs_resp_err   = sel64 ? b_resp_err   : a_resp_err;
    assign obs_mem_wstrb  = sel64 ? b_mem_wstrb  : {4'h0, a_mem_wstrb};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request; mem_ready is raised in MEM cycle number `waits`
    // (0-based), or never when waits < 0.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int waits,
                         input logic [63:0] rdata, input logic merr);
        int mcyc;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = rdata;
        mem_err    = merr;
        @(posedge clock); #1;
        req_valid  = 1'b0;
        req_addr   = '1;
        req_wdata  = '1;
        req_funct3 = 3'b111;
        req_we     = ~we;
        res_lat     = 1;
        mcyc        = 0;
        res_mv_seen = 1'b0;
        res_stable  = 1'b1;
        res_maddr   = '0;
        res_wdata   = '0;
        res_strb    = '0;
        res_mwe     = 1'b0;
        while (!obs_resp_valid && res_lat < 50) begin
            if (obs_mem_valid) begin
                if (!res_mv_seen) begin
                    res_maddr = obs_mem_addr;
                    res_wdata = obs_mem_wdata;
                    res_strb  = obs_mem_wstrb;
                    res_mwe   = obs_mem_we;
                end else if (obs_mem_addr !== res_maddr || obs_mem_wdata !== res_wdata ||
                             obs_mem_wstrb !== res_strb || obs_mem_we !== res_mwe) begin
                    res_stable = 1'b0;
                end
                res_mv_seen = 1'b1;
                mem_ready   = (mcyc == waits);
                mcyc++;
            end
            @(posedge clock); #1;
            mem_ready = 1'b0;
            res_lat++;
        end
        res_rdata      = obs_resp_rdata;
        res_err        = obs_resp_err;
        res_mv_at_resp = obs_mem_valid;
        @(posedge clock); #1;
        res_rv_after    = obs_resp_valid;
        res_ready_after = obs_req_ready;
        res_rdata_after = obs_resp_rdata;
        res_err_after   = obs_resp_err;
    endtask

    task automatic check_resp(input string tag, input int lat, input logic [63:0] rdata,
                              input logic [1:0] err);
        check_val({tag, "_lat"}, 64'(res_lat), 64'(lat));
        check_val({tag, "_rdata"}, res_rdata, rdata);
        check_val({tag, "_err"}, 64'(res_err), 64'(err));
        check_val({tag, "_pulse"}, 64'(res_rv_after), 64'd0);
        check_val({tag, "_ready"}, 64'(res_ready_after), 64'd1);
    endtask

    task automatic check_beat(input string tag, input logic [63:0] maddr, input logic [7:0] strb,
                              input logic [63:0] wdata, input logic mwe);
        check_val({tag, "_mv"}, 64'(res_mv_seen), 64'd1);
        check_val({tag, "_maddr"}, res_maddr, maddr);
        check_val({tag, "_strb"}, 64'(res_strb), 64'(strb));
        check_val({tag, "_wdata"}, res_wdata, wdata);
        check_val({tag, "_mwe"}, 64'(res_mwe), 64'(mwe));
        check_val({tag, "_stable"}, 64'(res_stable), 64'd1);
    endtask

    initial begin
        reset      = 1'b1;
        sel64      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        mem_err    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_ready", 64'(obs_req_ready), 64'd0);
        check_val("rst_rvalid", 64'(obs_resp_valid), 64'd0);
        check_val("rst_mvalid", 64'(obs_mem_valid), 64'd0);
        check_val("rst_rdata", obs_resp_rdata, 64'd0);
        check_val("rst_err", 64'(obs_resp_err), 64'd0);
        check_val("rst_maddr", obs_mem_addr, 64'd0);
        check_val("rst_strb", 64'(obs_mem_wstrb), 64'd0);
        check_val("rst_wdata", obs_mem_wdata, 64'd0);
        check_val("rst_mwe", 64'(obs_mem_we), 64'd0);
        reset = 1'b0;
        #1;
        check_val("rel_ready", 64'(obs_req_ready), 64'd1);
        @(posedge clock); #1;

        // LB sign-extended from top byte lane, one wait cycle.
        issue(1'b0, 3'b000, 64'h103, 64'h0, 1, 64'h80FF_0000, 1'b0);
        check_beat("lb", 64'h100, 8'h0, 64'h0, 1'b0);
        check_resp("lb", 3, 64'hFFFF_FF80, 2'b00);
        check_val("lb_hold_rdata", res_rdata_after, 64'hFFFF_FF80);

        issue(1'b1, 3'b001, 64'h202, 64'h1234_ABCD, 0, 64'h0, 1'b0);
        check_beat("sh", 64'h200, 8'hC, 64'hABCD_0000, 1'b1);
        check_resp("sh", 2, 64'h0, 2'b00);

        issue(1'b1, 3'b000, 64'h101, 64'h55, 0, 64'h0, 1'b0);
        check_beat("sb", 64'h100, 8'h2, 64'h0000_5500, 1'b1);
        check_resp("sb", 2, 64'h0, 2'b00);

        issue(1'b0, 3'b010, 64'h101, 64'h0, 0, 64'h0, 1'b0);
        check_val("lw_mis_mv", 64'(res_mv_seen), 64'd0);
        check_resp("lw_mis", 1, 64'h0, 2'b01);

        issue(1'b0, 3'b011, 64'h100, 64'h0, 0, 64'h0, 1'b0);
        check_val("ld32_mv", 64'(res_mv_seen), 64'd0);
        check_resp("ld32", 1, 64'h0, 2'b01);

        issue(1'b0, 3'b110, 64'h100, 64'h0, 0, 64'h0, 1'b0);
        check_resp("lwu32", 1, 64'h0, 2'b01);

        issue(1'b1, 3'b100, 64'h100, 64'h0, 0, 64'h0, 1'b0);
        check_val("sbu_mv", 64'(res_mv_seen), 64'd0);
        check_resp("sbu", 1, 64'h0, 2'b01);

        issue(1'b0, 3'b101, 64'h106, 64'h0, 0, 64'h8001_7FFF, 1'b0);
        check_resp("lhu", 2, 64'h0000_8001, 2'b00);

        issue(1'b0, 3'b001, 64'h106, 64'h0, 0, 64'h8001_7FFF, 1'b0);
        check_resp("lh", 2, 64'hFFFF_8001, 2'b00);

        issue(1'b0, 3'b100, 64'h102, 64'h0, 2, 64'h00AB_0000, 1'b0);
        check_resp("lbu", 4, 64'h0000_00AB, 2'b00);

        issue(1'b0, 3'b010, 64'h10, 64'h0, 0, 64'h1234_5678, 1'b1);
        check_resp("buserr", 2, 64'h1234_5678, 2'b10);

        issue(1'b0, 3'b010, 64'h100, 64'h0, -1, 64'h0, 1'b0);
        check_val("to_mv_drop", 64'(res_mv_at_resp), 64'd0);
        check_resp("to", 5, 64'h0, 2'b11);
        check_val("to_hold_err", 64'(res_err_after), 64'd3);

        issue(1'b0, 3'b010, 64'h100, 64'h0, 3, 64'hDEAD_BEEF, 1'b0);
        check_resp("to_race", 5, 64'hDEAD_BEEF, 2'b00);

        // Reset in the middle of a memory beat.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 64'h200;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check_val("mrst_mv_before", 64'(obs_mem_valid), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_val("mrst_mv", 64'(obs_mem_valid), 64'd0);
        check_val("mrst_ready", 64'(obs_req_ready), 64'd0);
        check_val("mrst_err", 64'(obs_resp_err), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_val("mrst_rel_ready", 64'(obs_req_ready), 64'd1);
        @(posedge clock); #1;
        check_val("mrst_rvalid", 64'(obs_resp_valid), 64'd0);
        check_val("mrst_idle_mv", 64'(obs_mem_valid), 64'd0);

        issue(1'b0, 3'b010, 64'h300, 64'h0, 0, 64'hCAFE_F00D, 1'b0);
        check_resp("post_rst", 2, 64'hCAFE_F00D, 2'b00);

        sel64 = 1'b1;
        #1;
        issue(1'b0, 3'b110, 64'h104, 64'h0, 0, 64'hF000_0000_1234_5678, 1'b0);
        check_beat("lwu64", 64'h100, 8'h00, 64'h0, 1'b0);
        check_resp("lwu64", 2, 64'h0000_0000_F000_0000, 2'b00);

        issue(1'b0, 3'b010, 64'h104, 64'h0, 0, 64'hF000_0000_1234_5678, 1'b0);
        check_resp("lw64", 2, 64'hFFFF_FFFF_F000_0000, 2'b00);

        issue(1'b1, 3'b011, 64'h108, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 1'b0);
        check_beat("sd64", 64'h108, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1);
        check_resp("sd64", 2, 64'h0, 2'b00);

        issue(1'b1, 3'b010, 64'h10C, 64'hFFFF_FFFF_CAFE_BABE, 1, 64'h0, 1'b0);
        check_beat("sw64", 64'h108, 8'hF0, 64'hCAFE_BABE_0000_0000, 1'b1);
        check_resp("sw64", 3, 64'h0, 2'b00);

        issue(1'b0, 3'b011, 64'h104, 64'h0, 0, 64'h0, 1'b0);
        check_resp("ld64_mis", 1, 64'h0, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
